// File: rtl/word_store_sequencer_pkg.sv
// Shared state encoding and byte-half identifiers for the word store sequencer.
package word_store_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Same meaning as the instruction register's LH select.
  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

endpackage

// File: rtl/word_store_sequencer_byte_lane_mux.sv
// Picks the byte of a 16-bit word and its little-endian address for a given half.
module word_store_sequencer_byte_lane_mux
  import word_store_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [15:0]           word,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic                  lh,
  output logic [7:0]            lane_byte,
  output logic [ADDR_WIDTH-1:0] lane_addr
);

  // High byte lives at base+1; the add wraps at the top of the address space.
  assign lane_byte = (lh == LH_HIGH) ? word[15:8] : word[7:0];
  assign lane_addr = (lh == LH_HIGH) ? base + ADDR_WIDTH'(1) : base;

endmodule

// File: rtl/word_store_sequencer.sv
// Stores a 16-bit word as two byte writes on an 8-bit memory port, Start/Done handshake.
module word_store_sequencer
  import word_store_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter bit LOW_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           data,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_wr,
  output logic                  lh,
  output logic                  busy,
  output logic                  done
);

  localparam logic FIRST_LH = LOW_FIRST ? LH_LOW : LH_HIGH;

  state_t                state, nxt_state;
  logic [15:0]           word_q, nxt_word;
  logic [ADDR_WIDTH-1:0] addr_q, nxt_addr;
  logic                  nxt_lh, nxt_wr;
  logic [7:0]            lane_byte;
  logic [ADDR_WIDTH-1:0] lane_addr;

  always_comb begin
    nxt_state = state;
    nxt_word  = word_q;
    nxt_addr  = addr_q;
    case (state)
      ST_IDLE: if (start) begin
        nxt_state = ST_FIRST;
        nxt_word  = data;
        nxt_addr  = address;
      end
      ST_FIRST:  if (mem_ready) nxt_state = ST_SECOND;
      ST_SECOND: if (mem_ready) nxt_state = ST_FINISH;
      default:   nxt_state = ST_IDLE;
    endcase
    nxt_wr = (nxt_state == ST_FIRST) || (nxt_state == ST_SECOND);
    nxt_lh = (nxt_state == ST_FIRST) ? FIRST_LH : ~FIRST_LH;
  end

  // Decoding from the next-state values lets every output come straight off a flop,
  // so the first byte is already on the bus in the cycle after Start is accepted.
  word_store_sequencer_byte_lane_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
    .word      (nxt_word),
    .base      (nxt_addr),
    .lh        (nxt_lh),
    .lane_byte (lane_byte),
    .lane_addr (lane_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      word_q   <= '0;
      addr_q   <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wr   <= 1'b0;
      lh       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt_state;
      word_q   <= nxt_word;
      addr_q   <= nxt_addr;
      mem_wr   <= nxt_wr;
      lh       <= nxt_wr ? nxt_lh : 1'b0;
      mem_data <= nxt_wr ? lane_byte : 8'h00;
      mem_addr <= nxt_wr ? lane_addr : '0;
      busy     <= (nxt_state != ST_IDLE);
      done     <= (nxt_state == ST_FINISH);
    end
  end

endmodule

// File: doc/word_store_sequencer.md
Name: word_store_sequencer

Overview:
Splits a 16-bit word, from a register or the ALU, into two byte writes to the 8-bit-wide memory. It is the write-side counterpart of the instruction register's two-phase byte load.
- Little-endian layout: low byte at Address, high byte at Address+1.
- Sits between the datapath and the memory port and is driven by the control unit with a Start/Done handshake.
- Honors a memory ready signal so slow memory models can stall the sequence.

Parameters:
ADDR_WIDTH, 16, width of the byte address bus.
LOW_FIRST, 1, 1 = write low byte first then high byte; 0 = high byte first. Byte-to-address mapping is unchanged either way.

Ports:
Clock  input  1  system clock; all state updates on its rising edge.
Reset  input  1  asynchronous, active-low reset.
Start  input  1  request pulse; sampled only in IDLE.
Data  input  16  word to store; captured on an accepted Start.
Address  input  ADDR_WIDTH  base byte address; captured on an accepted Start.
MemReady  input  1  memory accepts the current byte this cycle when 1.
MemAddr  output  ADDR_WIDTH  byte address of the current write.
MemData  output  8  byte being written.
MemWR  output  1  write strobe; high while a byte is presented.
LH  output  1  half being written: 1 = high byte, 0 = low byte.
Busy  output  1  high from the cycle after an accepted Start until Done.
Done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state = IDLE.
  - MemAddr, MemData, MemWR, LH, Busy, Done = 0.
  - Captured word and address registers = 0.
- States: IDLE, FIRST, SECOND, FINISH. Encoding is 2 bits.
- IDLE, Start=1:
  - Latch Data into word_q and Address into addr_q.
  - Go to FIRST.
  - Busy stays 0 in the acceptance cycle and rises with FIRST.
- IDLE, Start=0: hold. All outputs stay 0 except registers that are not visible.
- FIRST:
  - MemWR=1.
  - When LOW_FIRST=1: LH=0, MemData=word_q[7:0], MemAddr=addr_q.
  - When LOW_FIRST=0: LH=1, MemData=word_q[15:8], MemAddr=addr_q+1.
  - If MemReady=1, go to SECOND. Otherwise stay; outputs are held stable and unchanged.
- SECOND:
  - MemWR=1 and the other half is presented with its address. The high address is addr_q+1, modulo 2^ADDR_WIDTH, so address 0xFFFF wraps to 0x0000.
  - If MemReady=1, go to FINISH. Otherwise hold.
- FINISH:
  - Done=1 and MemWR=0 for exactly one cycle, then IDLE.
  - Busy=1 in FINISH and falls in IDLE.
- Outputs are registered. MemAddr, MemData and LH are decoded from state and the captured registers. Any combinational decode must be glitch-free relative to the clock edge.
- Zero-stall latency: Start at edge N → FIRST byte presented N+1, SECOND at N+2, Done at N+3, next Start accepted in IDLE at N+4.
- Start while Busy or in FINISH: ignored, with no queuing. Data and Address changes after acceptance have no effect.
- MemReady high outside FIRST/SECOND: ignored.
- Reset asserted mid-sequence: immediate return to IDLE. A partially written word is not completed, and no Done pulse is produced.
- Exactly one MemWR cycle per byte is consumed when MemReady is high. A byte is never written twice, and halves are never skipped.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_FIRST=2'd1, ST_SECOND=2'd2, ST_FINISH=2'd3;
  - LH_LOW=1'b0, LH_HIGH=1'b1, matching the instruction register's LH meaning.
- One optional sub-module, byte_lane_mux: selects word_q half and address offset from LH. It is purely combinational.
- Everything else stays in one module.

Test Plan:
- Reset, then Start with Data=16'hA55A, Address=16'h0040, MemReady=1, LOW_FIRST=1 → cycle+1: MemAddr=0040, MemData=5A, LH=0, MemWR=1; cycle+2: 0041, A5, LH=1; cycle+3: Done=1, MemWR=0; cycle+4: Busy=0.
- LOW_FIRST=0, Data=16'h1234, Address=16'h0010 → first write 0011/12 with LH=1, then 0010/34 with LH=0, then Done.
- MemReady=0 for 3 cycles in FIRST, then 1 → MemWR, MemAddr and MemData held constant during the stall; SECOND starts the cycle after MemReady=1; Done at Start+6.
- Address=16'hFFFF, Data=16'hBEEF → writes FFFF/EF then 0000/BE; no X on MemAddr.
- Second Start with Data=16'h0000 asserted during SECOND → ignored; bytes of the original word complete; only one Done pulse.
- Reset pulled low while in SECOND → all outputs 0 within the same cycle (asynchronous); no Done; a fresh Start afterwards completes normally.
